mux_ctrl_seq: RTL
=================

Name: mux_ctrl_seq

Overview:
- TX symbol sequencer that drives the K-code mux select (S), mux enable (enb) and mux data byte every symbol clock.
- Frames packets as STP/SDP … END/EDB.
- Inserts SKP ordered sets on a fixed interval, emits FTS and electrical-idle ordered sets on request, and fills gaps with logical idle (data 00).
- Sits between the link/packet layer and the symbol mux, ahead of 8b/10b encoding.

Parameters:
- SKP_INTERVAL, 1180, symbol clocks between SKP ordered-set insertions.
- SKP_CW, 11, width of the SKP interval counter; must hold SKP_INTERVAL.

Ports:
- clk  in  1  symbol clock
- reset_L  in  1  asynchronous active-low reset
- pkt_valid  in  1  packet byte available
- pkt_data  in  8  packet byte
- pkt_last  in  1  current byte is the final byte of the packet
- pkt_dllp  in  1  sampled at packet start: 1 = DLLP (SDP), 0 = TLP (STP)
- pkt_nullify  in  1  sampled with the last byte: close the packet with EDB instead of END
- pkt_ready  out  1  byte accepted this cycle (pkt_valid & pkt_ready)
- pkt_abort  out  1  one-cycle pulse on underrun abort
- fts_req  in  1  pulse: send n_fts FTS ordered sets
- n_fts  in  8  FTS ordered-set count, latched on fts_req
- fts_done  out  1  one-cycle pulse after the last FTS ordered set
- eidle_req  in  1  level: enter or hold electrical idle
- S  out  4  mux select
- enb  out  1  mux enable
- mux_data  out  8  data byte to the mux

Behaviour:
- Outputs: S, enb and mux_data are registered. Each symbol is decided in cycle N and appears in cycle N+1. pkt_ready is combinational, equal to (state == PKT_DATA).
- Reset (reset_L = 0, asynchronous): state = LIDLE; S = 0, enb = 0, mux_data = 0; pkt_abort = 0, fts_done = 0; SKP counter = 0, skp_pend = 0, fts count = 0.
- First symbol after reset release: logical idle (enb = 1, S = 0, mux_data = 00).
- Select codes: DATA = 0, COM = 1, PAD = 2, SKP = 3, STP = 4, SDP = 5, END = 6, EDB = 7, FTS = 8, IDL = 9.
- States:
  - LIDLE: emit logical idle.
  - PKT_START: emit STP or SDP.
  - PKT_DATA: emit S = DATA with mux_data = pkt_data.
  - PKT_END: emit END or EDB.
  - SKP_OS: emit COM, SKP, SKP, SKP.
  - FTS_OS: emit COM, FTS, FTS, FTS, repeated n_fts times.
  - EIOS: emit COM, IDL, IDL, IDL.
  - EIDLE: enb = 0, S = 0, mux_data = 0.
- Ordered sets use a 2-bit symbol index and are never interrupted.
- Arbitration only at a boundary (LIDLE, or the last symbol of PKT_END / an ordered set). Priority: skp_pend > eidle_req (enter EIOS) > fts pending > pkt_valid (enter PKT_START) > LIDLE.
- Packets are never split by SKP; a pending SKP waits for the packet to finish.
- PKT_DATA:
  - pkt_valid & pkt_last → go to PKT_END; EDB if pkt_nullify, else END.
  - pkt_valid = 0 (underrun) → emit EDB in place of a data byte, pulse pkt_abort, return to the boundary. The source discards the rest of the packet.
- SKP timer:
  - Increments every cycle outside EIDLE.
  - On reaching SKP_INTERVAL−1: wraps to 0 and sets skp_pend.
  - skp_pend clears in the cycle SKP_OS is entered.
  - An expiry while already pending is absorbed; no queueing.
  - In EIDLE the counter and skp_pend are held at 0.
- FTS:
  - fts_req with n_fts = 0 is ignored.
  - fts_req while FTS is pending or active is ignored.
  - fts_done pulses in the cycle after the final FTS symbol is decided.
- Electrical idle:
  - EIDLE persists while eidle_req = 1.
  - On eidle_req = 0, go to LIDLE (logical idle), with the SKP timer restarting from 0.
  - eidle_req dropping before EIOS starts cancels entry.
  - fts_req is accepted in EIDLE and served after exit.
- Reset mid-packet or mid-ordered-set: immediate return to the reset state; no END is emitted.

Decomposition:
- Shared package mux_ctrl_pkg:
  - 4-bit select constants (DATA … IDL).
  - State enumeration.
  - Ordered-set length constant (4).
- Sub-module skp_timer (counter, wrap and pending flag; inputs clk, reset_L, hold, clr_pend; output skp_pend).

Test Plan:
- Reset release with no requests → enb = 1, S = 0, mux_data = 00 every cycle; no SKP before cycle 1180.
- 3-byte TLP A1, B2, C3 (pkt_dllp = 0) → S sequence 4, 0, 0, 0, 6 with mux_data A1, B2, C3 on the data symbols; pkt_ready high exactly 3 cycles.
- 2-byte DLLP with pkt_nullify on the last byte → S sequence 5, 0, 0, 7.
- SKP_INTERVAL = 16, 20-byte TLP spanning the expiry → packet unbroken; then S sequence 1, 3, 3, 3; skp_pend cleared.
- fts_req with n_fts = 2 → S sequence 1, 8, 8, 8, 1, 8, 8, 8; fts_done a single pulse; then logical idle.
- eidle_req = 1 → S sequence 1, 9, 9, 9, then enb = 0; release eidle_req → logical idle.
- Underrun (pkt_valid dropped after byte 1) → S = 7 with pkt_abort pulse.
- Mid-packet reset → all outputs 0 asynchronously.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the TX symbol sequencer: mux select codes, FSM states
// and the ordered-set length.
package mux_ctrl_pkg;

    localparam logic [3:0] SelData = 4'd0;
    localparam logic [3:0] SelCom  = 4'd1;
    localparam logic [3:0] SelPad  = 4'd2;
    localparam logic [3:0] SelSkp  = 4'd3;
    localparam logic [3:0] SelStp  = 4'd4;
    localparam logic [3:0] SelSdp  = 4'd5;
    localparam logic [3:0] SelEnd  = 4'd6;
    localparam logic [3:0] SelEdb  = 4'd7;
    localparam logic [3:0] SelFts  = 4'd8;
    localparam logic [3:0] SelIdl  = 4'd9;

    localparam int unsigned OsLen = 4;

    typedef enum logic [2:0] {
        StLidle,
        StPktStart,
        StPktData,
        StPktEnd,
        StSkpOs,
        StFtsOs,
        StEios,
        StEidle
    } state_e;

endpackage

// File: rtl/skp_timer.sv
// SKP interval timer: free-running wrap counter that raises a sticky pending
// flag on each wrap; both are held at zero while hold is asserted.
module skp_timer #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_CW       = 11
) (
    input  logic clk,
    input  logic reset_L,
    input  logic hold,
    input  logic clr_pend,
    output logic skp_pend
);

    logic [SKP_CW-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              wrap;

    always_comb begin
        wrap   = (cnt_q == SKP_CW'(SKP_INTERVAL - 1));
        cnt_d  = wrap ? '0 : cnt_q + SKP_CW'(1);
        // A fresh expiry wins over a clear issued in the same cycle.
        pend_d = wrap ? 1'b1 : (clr_pend ? 1'b0 : pend_q);
        if (hold) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign skp_pend = pend_q;

endmodule

// File: rtl/mux_ctrl_seq.sv
// TX symbol sequencer: frames packets, inserts SKP/FTS/EIOS ordered sets and
// logical idle, and drives the registered K-code mux select, enable and data.
module mux_ctrl_seq
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_CW       = 11
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       pkt_valid,
    input  logic [7:0] pkt_data,
    input  logic       pkt_last,
    input  logic       pkt_dllp,
    input  logic       pkt_nullify,
    output logic       pkt_ready,
    output logic       pkt_abort,
    input  logic       fts_req,
    input  logic [7:0] n_fts,
    output logic       fts_done,
    input  logic       eidle_req,
    output logic [3:0] S,
    output logic       enb,
    output logic [7:0] mux_data
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] fts_cnt_q, fts_cnt_d;
    logic       end_edb_q, end_edb_d;
    logic [3:0] s_q, s_d;
    logic       enb_q, enb_d;
    logic [7:0] data_q, data_d;
    logic       abort_q, abort_d;
    logic       done_q, done_d;

    logic       skp_pend, clr_pend;
    logic       at_bnd, os_last, fts_dec;
    logic [7:0] fts_left;

    skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .SKP_CW      (SKP_CW)
    ) u_skp_timer (
        .clk     (clk),
        .reset_L (reset_L),
        .hold    (state_q == StEidle),
        .clr_pend(clr_pend),
        .skp_pend(skp_pend)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = '0;
        end_edb_d = end_edb_q;
        s_d       = SelData;
        enb_d     = 1'b1;
        data_d    = '0;
        abort_d   = 1'b0;
        done_d    = 1'b0;
        at_bnd    = 1'b0;
        os_last   = (idx_q == 2'(OsLen - 1));
        // fts_cnt_q counts ordered sets not yet finished, including the active one.
        fts_dec   = (state_q == StFtsOs) && os_last;
        fts_left  = fts_cnt_q - 8'(fts_dec);
        fts_cnt_d = fts_left;
        if (fts_req && (n_fts != 8'd0) && (fts_cnt_q == 8'd0)) begin
            fts_cnt_d = n_fts;
        end

        unique case (state_q)
            StLidle: at_bnd = 1'b1;
            StPktStart: begin
                s_d     = pkt_dllp ? SelSdp : SelStp;
                state_d = StPktData;
            end
            StPktData: begin
                if (pkt_valid) begin
                    data_d = pkt_data;
                    if (pkt_last) begin
                        state_d   = StPktEnd;
                        end_edb_d = pkt_nullify;
                    end
                end else begin
                    s_d     = SelEdb;
                    abort_d = 1'b1;
                    at_bnd  = 1'b1;
                end
            end
            StPktEnd: begin
                s_d    = end_edb_q ? SelEdb : SelEnd;
                at_bnd = 1'b1;
            end
            StSkpOs: begin
                s_d    = (idx_q == 2'd0) ? SelCom : SelSkp;
                idx_d  = idx_q + 2'd1;
                at_bnd = os_last;
            end
            StFtsOs: begin
                s_d    = (idx_q == 2'd0) ? SelCom : SelFts;
                idx_d  = idx_q + 2'd1;
                at_bnd = os_last;
                done_d = fts_dec && (fts_left == 8'd0);
            end
            StEios: begin
                s_d   = (idx_q == 2'd0) ? SelCom : SelIdl;
                idx_d = idx_q + 2'd1;
                if (os_last) state_d = StEidle;
            end
            StEidle: begin
                enb_d = 1'b0;
                if (!eidle_req) state_d = StLidle;
            end
            default: state_d = StLidle;
        endcase

        if (at_bnd) begin
            if (skp_pend)               state_d = StSkpOs;
            else if (eidle_req)         state_d = StEios;
            else if (fts_left != 8'd0)  state_d = StFtsOs;
            else if (pkt_valid)         state_d = StPktStart;
            else                        state_d = StLidle;
        end
        clr_pend = at_bnd && skp_pend;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= StLidle;
            idx_q     <= '0;
            fts_cnt_q <= '0;
            end_edb_q <= 1'b0;
            s_q       <= '0;
            enb_q     <= 1'b0;
            data_q    <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fts_cnt_q <= fts_cnt_d;
            end_edb_q <= end_edb_d;
            s_q       <= s_d;
            enb_q     <= enb_d;
            data_q    <= data_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
        end
    end

    assign pkt_ready = (state_q == StPktData);
    assign pkt_abort = abort_q;
    assign fts_done  = done_q;
    assign S         = s_q;
    assign enb       = enb_q;
    assign mux_data  = data_q;

endmodule
